// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sorting-network front end.
package sorter_pkg;

  localparam int unsigned PAD_MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic sign_ctrl;
  } ctrl_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    SEND = 2'd2
  } loader_state_e;

  // Sentinel that sorts above every real element: unsigned max or signed max.
  function automatic logic [PAD_MAX_W-1:0] pad_value(input logic sign, input int unsigned width);
    logic [PAD_MAX_W-1:0] ones;
    if (width >= PAD_MAX_W) ones = '1;
    else                    ones = (PAD_MAX_W'(1) << width) - PAD_MAX_W'(1);
    return sign ? (ones >> 1) : ones;
  endfunction

endpackage

// File: rtl/sorter_loader_if.sv
// Element stream in / packed vector out bundle of the sorter loader.
interface sorter_loader_if #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NUM       = 8
);
  import sorter_pkg::*;

  localparam int unsigned CNT_W = $clog2(NUM) + 1;

  logic                     sign_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [DATAWIDTH-1:0]     in_data_i;
  logic                     in_last_i;
  logic [NUM*DATAWIDTH-1:0] out_data_o;
  ctrl_t                    out_ctrl_o;
  logic [CNT_W-1:0]         out_count_o;
  logic                     out_ready_i;

  modport slave (
    input  sign_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_ctrl_o, out_count_o
  );

  modport master (
    output sign_i, in_valid_i, in_data_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_ctrl_o, out_count_o
  );
endinterface

// File: rtl/sorter_loader.sv
// Packs NUM streamed elements into one vector for the sorting network.
// Short-group padding is enabled with `define SORTER_LOADER_PAD_EN.
module sorter_loader
  import sorter_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NUM       = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sorter_loader_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NUM) + 1;

  loader_state_e    state;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;
  logic             at_end_c;

  assign accept_c = bus.in_valid_i & bus.in_ready_o;
  assign at_end_c = (cnt == CNT_W'(NUM - 1));

`ifdef SORTER_LOADER_PAD_EN
  logic [DATAWIDTH-1:0] pad_c;
  assign pad_c = DATAWIDTH'(pad_value(bus.out_ctrl_o.sign_ctrl, DATAWIDTH));
`else
  logic unused_last_c;
  assign unused_last_c = bus.in_last_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= FILL;
      cnt             <= '0;
      bus.in_ready_o  <= 1'b0;
      bus.out_data_o  <= '0;
      bus.out_ctrl_o  <= '0;
      bus.out_count_o <= '0;
    end else begin
`ifndef SORTER_LOADER_PAD_EN
      bus.out_count_o <= CNT_W'(NUM);
`endif
      case (state)
        FILL: begin
          bus.in_ready_o <= 1'b1;
          if (accept_c) begin
            for (int unsigned k = 0; k < NUM; k++) begin
              if (cnt == CNT_W'(k)) bus.out_data_o[k*DATAWIDTH +: DATAWIDTH] <= bus.in_data_i;
            end
            // Sign is owned by the first beat of the vector.
            if (cnt == '0) bus.out_ctrl_o.sign_ctrl <= bus.sign_i;
            cnt <= cnt + CNT_W'(1);
            if (at_end_c) begin
              state                <= SEND;
              bus.in_ready_o       <= 1'b0;
              bus.out_ctrl_o.valid <= 1'b1;
`ifdef SORTER_LOADER_PAD_EN
              bus.out_count_o      <= CNT_W'(NUM);
`endif
            end
`ifdef SORTER_LOADER_PAD_EN
            else if (bus.in_last_i) begin
              state           <= PAD;
              bus.in_ready_o  <= 1'b0;
              bus.out_count_o <= cnt + CNT_W'(1);
            end
`endif
          end
        end
`ifdef SORTER_LOADER_PAD_EN
        PAD: begin
          // cnt now holds the real element count; fill everything above it.
          for (int unsigned k = 0; k < NUM; k++) begin
            if (CNT_W'(k) >= cnt) bus.out_data_o[k*DATAWIDTH +: DATAWIDTH] <= pad_c;
          end
          state                <= SEND;
          bus.out_ctrl_o.valid <= 1'b1;
        end
`endif
        SEND: begin
          if (bus.out_ready_i) begin
            state                <= FILL;
            cnt                  <= '0;
            bus.out_ctrl_o.valid <= 1'b0;
            bus.in_ready_o       <= 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_loader.sv
// Randomized bench for sorter_loader against a queue-based vector model.
module tb_sorter_loader;
  localparam int unsigned DW  = 8;
  localparam int unsigned NUM = 8;
  localparam int unsigned VW  = NUM * DW;

  typedef struct {
    logic [VW-1:0] data;
    int            count;
    logic          sign;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up;
  int   rdy_mode = 0;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int vec_done   = 0;

  logic [DW-1:0] beats[$];
  exp_t          expq[$];
  logic          first_sign;
  logic [VW-1:0] last_vec;
  int            last_cnt;
  logic          last_sign;

  sorter_loader_if #(.DATAWIDTH(DW), .NUM(NUM)) bus ();

  sorter_loader #(.DATAWIDTH(DW), .NUM(NUM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) up <= 1'b0;
    else     up <= 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_evt(input string name, input int act, input int exp);
    compared++;
    mismatched++;
    $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: collect accepted beats, emit an expected vector with its due cycle.
  task automatic model_complete(input logic padded);
    exp_t          e;
    logic [63:0]   sent;
    int            n;
    n    = beats.size();
    sent = first_sign ? ((64'd1 << (DW - 1)) - 64'd1) : ((64'd1 << DW) - 64'd1);
    for (int k = 0; k < NUM; k++)
      e.data[k*DW +: DW] = (k < n) ? beats[k] : DW'(sent);
    e.count = n;
    e.sign  = first_sign;
    e.due   = cyc + (padded ? 2 : 1);
    expq.push_back(e);
    beats.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_in_ready", 64'(bus.in_ready_o), 64'd0);
      chk("rst_data", 64'(bus.out_data_o), 64'd0);
      chk("rst_ctrl", 64'(bus.out_ctrl_o), 64'd0);
      chk("rst_count", 64'(bus.out_count_o), 64'd0);
      beats.delete();
      expq.delete();
    end else begin
      chk("in_ready", 64'(bus.in_ready_o), 64'(up && expq.size() == 0));
      if (bus.out_ctrl_o.valid) begin
        if (expq.size() == 0) fail_evt("unexpected_valid", 1, 0);
        else begin
          if (cyc < expq[0].due) fail_evt("early_valid_cycle", cyc, expq[0].due);
          chk("out_data", 64'(bus.out_data_o), 64'(expq[0].data));
          chk("out_count", 64'(bus.out_count_o), 64'(expq[0].count));
          chk("sign_ctrl", 64'(bus.out_ctrl_o.sign_ctrl), 64'(expq[0].sign));
          if (bus.out_ready_i) begin
            last_vec  = bus.out_data_o;
            last_cnt  = int'(bus.out_count_o);
            last_sign = bus.out_ctrl_o.sign_ctrl;
            vec_done++;
            void'(expq.pop_front());
          end
        end
      end else if (expq.size() != 0 && cyc >= expq[0].due) begin
        fail_evt("late_valid_cycle", cyc, expq[0].due);
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        if (beats.size() == 0) first_sign = bus.sign_i;
        beats.push_back(bus.in_data_i);
        if (beats.size() == NUM) model_complete(1'b0);
`ifdef SORTER_LOADER_PAD_EN
        else if (bus.in_last_i) model_complete(1'b1);
`endif
      end
    end
  end

  // Downstream ready: 0 = always, 1 = random, 2 = stalled.
  initial begin
    bus.out_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready_i = 1'b1;
        1:       bus.out_ready_i = ($urandom_range(0, 2) != 0);
        default: bus.out_ready_i = 1'b0;
      endcase
    end
  end

  task automatic beat(input logic [DW-1:0] d, input logic l, input logic s);
    int n = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = d;
    bus.in_last_i  = l;
    bus.sign_i     = s;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready_o && n < 200);
    if (!bus.in_ready_o) fail_evt("beat_accept_timeout", n, 200);
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_vec();
    int start = vec_done;
    int n = 0;
    while (vec_done == start && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (vec_done == start) fail_evt("vector_timeout", n, 200);
    #1;
  endtask

  task automatic chk_slots_seq(input string name, input int first, input int step);
    for (int k = 0; k < NUM; k++)
      chk($sformatf("%s_slot%0d", name, k), 64'(last_vec[k*DW +: DW]), 64'(DW'(first + step * k)));
  endtask

  initial begin
    int n;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = '0;
    bus.in_last_i  = 1'b0;
    bus.sign_i     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready_lit", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Unsigned full vector 8..1.
    for (int i = 0; i < NUM; i++) beat(DW'(8 - i), 1'b0, 1'b0);
    wait_vec();
    chk_slots_seq("full", 8, -1);
    chk("full_count", 64'(last_cnt), 64'd8);
    chk("full_sign", 64'(last_sign), 64'd0);

    // Stalled SEND: outputs held, no beats taken.
    rdy_mode = 2;
    for (int i = 0; i < NUM; i++) beat(DW'(i + 1), 1'b0, 1'b1);
    n = 0;
    while (!bus.out_ctrl_o.valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.out_ctrl_o.valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready_o), 64'd0);
    end
    rdy_mode = 0;
    wait_vec();
    bus.in_valid_i = 1'b0;
    chk_slots_seq("hold", 1, 1);
    chk("hold_sign", 64'(last_sign), 64'd1);

    // Reset after half a vector, then a clean vector.
    for (int i = 0; i < 4; i++) beat(DW'(8'hC0 + i), 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_data", 64'(bus.out_data_o), 64'd0);
    chk("async_rst_ctrl", 64'(bus.out_ctrl_o), 64'd0);
    chk("async_rst_count", 64'(bus.out_count_o), 64'd0);
    chk("async_rst_ready", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < NUM; i++) beat(DW'(i + 1), 1'b0, 1'b0);
    wait_vec();
    chk_slots_seq("post_rst", 1, 1);
    chk("post_rst_sign", 64'(last_sign), 64'd0);

`ifdef SORTER_LOADER_PAD_EN
    beat(8'h80, 1'b0, 1'b1);
    beat(8'h05, 1'b0, 1'b0);
    beat(8'hFF, 1'b1, 1'b0);
    wait_vec();
    chk("pad_s_slot0", 64'(last_vec[0 +: 8]), 64'h80);
    chk("pad_s_slot1", 64'(last_vec[8 +: 8]), 64'h05);
    chk("pad_s_slot2", 64'(last_vec[16 +: 8]), 64'hFF);
    for (int k = 3; k < NUM; k++) chk($sformatf("pad_s_slot%0d", k), 64'(last_vec[k*DW +: DW]), 64'h7F);
    chk("pad_s_count", 64'(last_cnt), 64'd3);
    chk("pad_s_sign", 64'(last_sign), 64'd1);
    beat(8'h10, 1'b1, 1'b0);
    wait_vec();
    chk("pad_u_slot0", 64'(last_vec[0 +: 8]), 64'h10);
    for (int k = 1; k < NUM; k++) chk($sformatf("pad_u_slot%0d", k), 64'(last_vec[k*DW +: DW]), 64'hFF);
    chk("pad_u_count", 64'(last_cnt), 64'd1);
`else
    beat(8'd1, 1'b0, 1'b0);
    beat(8'd2, 1'b0, 1'b0);
    beat(8'd3, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("nopad_no_valid", 64'(bus.out_ctrl_o.valid), 64'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 4; i <= NUM; i++) beat(DW'(i), 1'b0, 1'b0);
    wait_vec();
    chk_slots_seq("nopad", 1, 1);
    chk("nopad_count", 64'(last_cnt), 64'd8);
`endif

    // Random groups, gaps, per-beat sign noise and random backpressure.
    rdy_mode = 1;
    repeat (40) begin
      int len;
      len = $urandom_range(1, NUM);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        beat(DW'($urandom), (i == len - 1), 1'($urandom_range(0, 1)));
      end
    end
    n = 0;
    while (beats.size() != 0 && n < NUM) begin
      beat(DW'($urandom), 1'b0, 1'b0);
      n++;
    end
    rdy_mode = 0;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() != 0) fail_evt("drain_timeout", expq.size(), 0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sorter_loader.md
# sorter_loader

Stream-to-vector front end for the sorting network. It accepts one element per cycle over a valid/ready handshake and packs NUM elements into one parallel vector. Short final groups are padded so that the padding sorts to the top. The vector is then issued with a `ctrl_t` word to the first compare-and-swap stage. The block is the producing end of the sorter's `x*_i`/`ctrl_i` interface.

## Interface
- `DATAWIDTH`, 8: element width in bits.
- `NUM`, 8: elements per vector; power of two, at least 2.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: reset, asynchronous, active-high.
- `sign_i`  in  1: 0 = unsigned, 1 = signed; sampled with the first beat of each vector.
- `in_valid_i`  in  1: input element valid.
- `in_ready_o`  out  1: block can accept an element.
- `in_data_i`  in  DATAWIDTH: input element.
- `in_last_i`  in  1: marks the final element of the current group.
- `out_data_o`  out  NUM*DATAWIDTH: packed vector; slot k is bits [k*DATAWIDTH +: DATAWIDTH].
- `out_ctrl_o`  out  ctrl_t: `valid` = vector present; `sign_ctrl` = latched sign.
- `out_count_o`  out  $clog2(NUM)+1: number of real (non-pad) elements, 1..NUM.
- `out_ready_i`  in  1: downstream accepts the vector.

## Operation
- States are FILL, PAD and SEND.
- Reset values:
  - state = FILL, slot counter = 0.
  - all registered outputs are 0, including `in_ready_o`, `out_data_o`, `out_ctrl_o` = '{0,0} and `out_count_o`.
  - `in_ready_o` rises on the first clock edge after `rst_i` deasserts.
- FILL:
  - `in_ready_o` = 1.
  - A beat is accepted when `in_valid_i & in_ready_o`. It writes slot[cnt], and cnt increments.
  - On the first beat of a vector (cnt = 0), `sign_i` is latched. Any change to `sign_i` later in the vector is ignored.
  - If the accepted beat has cnt = NUM-1, go to SEND; the `in_last_i` value is irrelevant.
  - If the accepted beat has `in_last_i` = 1 and cnt < NUM-1, go to PAD.
- PAD:
  - Lasts exactly one cycle; `in_ready_o` = 0.
  - Every slot with index >= count is written with the sentinel, then go to SEND.
  - Sentinel is all-ones when unsigned and 0x7F..F (signed maximum) when signed.
- SEND:
  - `out_ctrl_o.valid` = 1 and `in_ready_o` = 0.
  - `out_data_o`, `out_ctrl_o` and `out_count_o` are held stable until `out_ready_i` = 1.
  - On that cycle go to FILL with cnt = 0. `valid` drops and `in_ready_o` rises on the next edge.
- `out_data_o` only changes on accepted beats or PAD writes; slots not yet written keep stale values.
- Reset mid-operation discards the partial vector and any pending vector; no output is produced for it.

## Timing
- Full vector: last beat accepted at edge t; `out_ctrl_o.valid` = 1 from edge t+1.
- Padded vector: last beat accepted at edge t; PAD occupies t+1; `valid` = 1 from edge t+2.
- Issue interval with `out_ready_i` tied high: NUM+1 cycles for a full vector (NUM fill cycles plus one SEND cycle).
- No combinational path from `in_valid_i` or `out_ready_i` to any output; all outputs are registered.

## Configuration
- `SORTER_LOADER_PAD_EN` defined:
  - PAD state and `in_last_i` handling are as above.
  - `out_count_o` reports the real element count.
- `SORTER_LOADER_PAD_EN` undefined:
  - `in_last_i` is ignored and the PAD state is absent.
  - A vector is issued only after NUM accepted beats.
  - `out_count_o` is constant NUM.

## Structure
- `sorter_pkg` holds:
  - `ctrl_t` (`valid` and `sign_ctrl`, packed in that order).
  - the state enum `loader_state_e`.
  - the function `pad_value(sign, width)` that returns the sentinel.
- No sub-module; a single flat block.

## Test plan
- Unsigned, NUM=8, beats 8,7,…,1 back-to-back with `out_ready_i`=1 -> `valid` rises one cycle after the 8th beat; slot0=8 … slot7=1; `out_count_o`=8; `sign_ctrl`=0.
- Signed, 3 beats 0x80, 0x05, 0xFF with `in_last_i` on the third -> `valid` two cycles later; slots 3..7 = 0x7F; `out_count_o`=3; `sign_ctrl`=1.
- Unsigned short vector of 1 beat 0x10 with last -> slot0=0x10; slots 1..7 = 0xFF; `out_count_o`=1.
- Hold `out_ready_i`=0 for 5 cycles in SEND -> `in_ready_o`=0 and outputs stable throughout; next vector accepted only after the handshake.
- Assert `rst_i` after 4 of 8 beats -> all outputs 0 immediately; a following full vector 1..8 emits 1..8 with no residue from the aborted one.
- With `SORTER_LOADER_PAD_EN` undefined, `in_last_i`=1 on beat 3 -> no output until beat 8; `out_count_o`=8.
